layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
- Top-level scheduler for the 4-unit neural datapath.
- For each layer: streams that layer's 16 weights from weight RAM into the four neural units, fires the unit sum trigger, waits until all units report done, then advances to the next layer.
- Sits between the ROM/data-bank start handshake and the weight RAM, the RAM mux and the neural units.
- Owns the layer and layer_sel sequencing.

Parameters:
- NUM_LAYERS, 4, layers per inference (1..4); layer index is 2 bits.
- RAM_LATENCY, 1, cycles from ram_rd/ram_addr to valid RAM data (1..3).
- ADDR_W, 10, weight RAM address width.
- TIMEOUT_CYCLES, 255, WAIT_DONE watchdog limit (used only with LAYER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a full inference; sampled only in IDLE.
- layer_done  input  4  per-unit layer-complete flags, bit n from neural unit n.
- ram_addr  output  ADDR_W  weight RAM read address.
- ram_rd  output  1  read strobe, high while ram_addr is valid.
- unit_sel  output  2  target neural unit for the current weight write.
- unit_addr  output  2  weight slot within the target unit.
- weight_wr  output  1  RAM data valid; write it into unit unit_sel, slot unit_addr.
- sum_trigger  output  1  one-cycle pulse; units compute the layer sum.
- layer  output  2  current layer index.
- layer_sel  output  1  0 = units take external input (layer 0); 1 = units take fed-back layer outputs.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last layer completes.
- error  output  1  sticky watchdog flag; cleared by reset or by the next accepted start.

Behaviour:
- Reset (async, reset low): state = IDLE. All outputs 0: ram_addr, ram_rd, unit_sel, unit_addr, weight_wr, sum_trigger, layer, layer_sel, busy, done, error. The read-latency pipeline is flushed.
- States: IDLE, LOAD, DRAIN, SUM, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - start=1 moves to LOAD; layer=0, layer_sel=0, weight counter=0, error cleared.
  - start while busy is ignored; it is not queued.
- LOAD: exactly 16 consecutive cycles, ram_rd=1.
  - Counter k runs 0..15; unit = k[3:2], slot = k[1:0].
  - ram_addr = layer*16 + k, zero-extended to ADDR_W.
  - After k=15, go to DRAIN.
- Read pipeline:
  - {unit, slot, ram_rd} is delayed RAM_LATENCY cycles and drives unit_sel, unit_addr and weight_wr.
  - weight_wr therefore asserts RAM_LATENCY cycles after the matching ram_rd.
  - Exactly 16 weight_wr pulses per layer, in order unit0 slot0..3, then unit1, and so on to unit3 slot3.
- DRAIN: RAM_LATENCY cycles with ram_rd=0 until the last weight_wr retires, then SUM.
- SUM: sum_trigger=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE:
  - layer_done is ignored in the first cycle after sum_trigger (stale-flag blanking).
  - From the second cycle on, layer_done==4'b1111 moves to NEXT.
  - Partial done bits do nothing.
- NEXT:
  - If layer==NUM_LAYERS-1, go to FINISH.
  - Otherwise layer+1, layer_sel=1, k=0, go to LOAD.
- FINISH: done=1 for one cycle; layer holds its last value; then IDLE. layer and layer_sel return to 0 on the next start.
- Per-layer latency: 16 + RAM_LATENCY + 1 + W + 1 cycles, where W ≥ 2 is the WAIT_DONE dwell.
- Start-to-done latency: 1 + that sum over all layers.
- Reset mid-operation aborts immediately: no further ram_rd, weight_wr or sum_trigger; pipeline cleared.
- A start asserted in the same cycle as done is ignored, because the block is not yet in IDLE.
- ram_addr never exceeds NUM_LAYERS*16-1.

Optional Feature:
- Macro: LAYER_TIMEOUT_EN.
- Defined:
  - A WAIT_DONE cycle counter is reset on entry.
  - If TIMEOUT_CYCLES elapse without all four done bits, error is set (sticky) and the state goes to FINISH. done pulses, busy drops, and the remaining layers are skipped.
- Undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - error is tied to 0.

Test Plan:
- Reset, then start pulse, NUM_LAYERS=1, RAM_LATENCY=1; layer_done driven to 4'hF 3 cycles after sum_trigger:
  - ram_addr runs 0..15 over 16 cycles.
  - weight_wr runs 16 cycles offset by 1, with (unit_sel, unit_addr) from (0,0) to (3,3).
  - One sum_trigger, then done one cycle after NEXT.
  - busy falls with done.
- NUM_LAYERS=4, layer_done returned 2 cycles after each sum_trigger:
  - ram_addr bases 0, 16, 32, 48.
  - layer 0→3; layer_sel=0 only in layer 0.
  - 4 sum_triggers, 64 weight_wr pulses, single done.
- RAM_LATENCY=3:
  - Each weight_wr lags its ram_rd by exactly 3 cycles.
  - DRAIN lasts 3 cycles.
  - sum_trigger occurs 1 cycle after the last weight_wr.
- layer_done held at 4'hF during SUM and the blank cycle, and 4'b0111 thereafter: the sequencer must not advance. Raising bit 3 advances on the next cycle.
- Extra start pulses during LOAD and in the done cycle are ignored. reset pulled low mid-LOAD (k=7): all outputs 0 immediately, and a fresh start restarts at ram_addr 0.
- With LAYER_TIMEOUT_EN and TIMEOUT_CYCLES=8, layer_done held at 0: error=1 and done pulses 8 cycles after entering WAIT_DONE. The next start clears error.

Source files
------------

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//   Top-level scheduler for the 4-unit neural datapath. For every layer it
//   streams the 16 layer weights out of weight RAM into the neural units,
//   pulses the unit sum trigger, waits for all four units to report done and
//   then advances to the next layer. After the last layer it pulses done.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   start        one-cycle inference request, honoured only while idle
//   layer_done   per-unit layer-complete flags (bit n = unit n)
//   ram_addr     weight RAM read address (layer*16 + k)
//   ram_rd       read strobe, high while ram_addr is valid
//   unit_sel     target unit of the current weight write
//   unit_addr    weight slot within the target unit
//   weight_wr    RAM data valid, write into unit_sel/unit_addr
//   sum_trigger  one-cycle pulse: units compute the layer sum
//   layer        current layer index
//   layer_sel    0 = external input (layer 0), 1 = fed-back layer outputs
//   busy         high whenever not idle
//   done         one-cycle pulse when the last layer completes
//   error        sticky WAIT_DONE watchdog flag
//
// Build option:
//   LAYER_TIMEOUT_EN  enables the WAIT_DONE watchdog (TIMEOUT_CYCLES). When
//                     undefined the sequencer waits indefinitely and error
//                     is tied low.
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int unsigned NUM_LAYERS     = 4,
  parameter int unsigned RAM_LATENCY    = 1,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        layer_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic [1:0]        unit_sel,
  output logic [1:0]        unit_addr,
  output logic              weight_wr,
  output logic              sum_trigger,
  output logic [1:0]        layer,
  output logic              layer_sel,
  output logic              busy,
  output logic              done,
  output logic              error
);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_bad_num_layers
    $error("layer_sequencer: NUM_LAYERS must be 1..4");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 3) begin : g_bad_ram_latency
    $error("layer_sequencer: RAM_LATENCY must be 1..3");
  end
  if (ADDR_W < 6) begin : g_bad_addr_w
    $error("layer_sequencer: ADDR_W must hold layer*16+k (>= 6 bits)");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("layer_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, SUM, WAIT_DONE, NEXT, FINISH
  } state_t;

  // Tag travelling alongside each RAM read until its data is valid.
  typedef struct packed {
    logic       wr;
    logic [3:0] k;
  } rd_tag_t;

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              first_q, first_d;
  logic [1:0]        layer_q, layer_d;
  logic              layer_sel_q, layer_sel_d;
  logic              ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              sum_trigger_q, sum_trigger_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  rd_tag_t           pipe_q [RAM_LATENCY];
  rd_tag_t           pipe_d [RAM_LATENCY];

`ifdef LAYER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wcnt_q, wcnt_d;
  logic            error_q, error_d;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    dcnt_d      = dcnt_q;
    first_d     = 1'b0;
    layer_d     = layer_q;
    layer_sel_d = layer_sel_q;
`ifdef LAYER_TIMEOUT_EN
    wcnt_d      = wcnt_q;
    error_d     = error_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          k_d         = '0;
          layer_d     = '0;
          layer_sel_d = 1'b0;
`ifdef LAYER_TIMEOUT_EN
          error_d     = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (k_q == 4'd15) begin
          state_d = DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DRAIN: begin
        if (dcnt_q == 2'(RAM_LATENCY - 1)) begin
          state_d = SUM;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      SUM: begin
        state_d = WAIT_DONE;
        first_d = 1'b1;
`ifdef LAYER_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WAIT_DONE: begin
        // first_q blanks done flags that may still be high from the previous layer.
        if (!first_q && layer_done == 4'hF) begin
          state_d = NEXT;
        end
`ifdef LAYER_TIMEOUT_EN
        else if (wcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FINISH;
          error_d = 1'b1;
        end
        wcnt_d = wcnt_q + 1'b1;
`endif
      end
      NEXT: begin
        if (layer_q == 2'(NUM_LAYERS - 1)) begin
          state_d = FINISH;
        end else begin
          state_d     = LOAD;
          layer_d     = layer_q + 2'd1;
          layer_sel_d = 1'b1;
          k_d         = '0;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    ram_rd_d   = (state_d == LOAD);
    ram_addr_d = '0;
    if (ram_rd_d) begin
      ram_addr_d[5:0] = {layer_d, k_d};
    end
    sum_trigger_d = (state_d == SUM);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == FINISH);

    pipe_d[0].wr = ram_rd_q;
    pipe_d[0].k  = ram_rd_q ? k_q : 4'd0;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      dcnt_q        <= '0;
      first_q       <= 1'b0;
      layer_q       <= '0;
      layer_sel_q   <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_addr_q    <= '0;
      sum_trigger_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
`ifdef LAYER_TIMEOUT_EN
      wcnt_q        <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      dcnt_q        <= dcnt_d;
      first_q       <= first_d;
      layer_q       <= layer_d;
      layer_sel_q   <= layer_sel_d;
      ram_rd_q      <= ram_rd_d;
      ram_addr_q    <= ram_addr_d;
      sum_trigger_q <= sum_trigger_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
`ifdef LAYER_TIMEOUT_EN
      wcnt_q        <= wcnt_d;
      error_q       <= error_d;
`endif
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_rd      = ram_rd_q;
  assign weight_wr   = pipe_q[RAM_LATENCY-1].wr;
  assign unit_sel    = pipe_q[RAM_LATENCY-1].k[3:2];
  assign unit_addr   = pipe_q[RAM_LATENCY-1].k[1:0];
  assign sum_trigger = sum_trigger_q;
  assign layer       = layer_q;
  assign layer_sel   = layer_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef LAYER_TIMEOUT_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule
